// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the {pc, instr} prefetch entry type.
package fetch_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch_entry_t with flush; push+pop when full is legal.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the fetch PC, reads the ROM each cycle and feeds decode through a prefetch FIFO.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = AW,
  parameter int DATA_WIDTH = DW,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic                     fetch_fault
);
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [CW-1:0] count;
  logic push, pop;
  fetch_entry_t head;
  assign rom_addr  = fetch_pc;
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign push      = !redirect_valid && (count < CW'(FIFO_DEPTH) || pop);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect_valid),
    .push (push),
    .pop  (pop),
    .din  ('{pc: fetch_pc, instr: rom_instr}),
    .head (head),
    .count(count)
  );
  // Misaligned targets are rounded down to the word and flagged until the next aligned redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      fetch_fault <= |redirect_pc[1:0];
    end else if (push) begin
      fetch_pc    <= fetch_pc + ADDRESS_WIDTH'(INSTR_BYTES);
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: random and directed stimulus checked against a queue-based fetch model.
module tb_instr_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rom_addr, rom_instr, redirect_pc, out_pc, out_instr;
  logic redirect_valid = 1'b0, out_ready = 1'b0, out_valid, fetch_fault;
  int n_tests = 0, n_fail = 0;
  logic [31:0] q[$];
  logic [31:0] m_pc = 32'h0;
  logic m_fault = 1'b0;

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h1111_1111;
  endfunction

  assign rom_instr = rom_fn(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic do_pop;
    rst = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    if (r) begin
      q.delete();
      m_pc = 32'h0;
      m_fault = 1'b0;
    end else if (rv) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
      m_fault = |rpc[1:0];
    end else begin
      do_pop = (q.size() != 0) && rdy;
      if (do_pop) void'(q.pop_front());
      if (q.size() < 2) begin
        q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("rom_addr", rom_addr, m_pc);
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (q.size() != 0) begin
      check("out_pc", out_pc, q[0]);
      check("out_instr", out_instr, rom_fn(q[0]));
    end
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    redirect_pc = 32'h0;
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    run(6, 1'b1);
    run(5, 1'b0);
    run(4, 1'b1);
    run(3, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    run(4, 1'b1);
    cycle(1'b0, 1'b1, 32'h102, 1'b1);
    run(4, 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b0);
    run(3, 1'b1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    run(6, 1'b1);
    run(3, 1'b0);
    cycle(1'b1, 1'b1, 32'h300, 1'b1);
    run(4, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFF);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 9) < 7);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
